// File: rtl/line_buffer_pkg.sv
// Shared types and sizes for the single-line buffer between the RV32I core and burst memory.
package rv32i_types;
  localparam int LB_LINE_BITS = 256;
  localparam int LB_BEAT_BITS = 64;
  localparam int LB_BEATS     = 4;
  localparam int LB_WORDS     = LB_LINE_BITS / 32;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    WB,
    FILL
  } lb_state_t;
endpackage

// File: rtl/line_buffer_line_merge.sv
// Combinational byte-enable merge of one 32-bit word into a selected word of a 256-bit line.
module line_merge
  import rv32i_types::*;
(
  input  logic [LB_LINE_BITS-1:0] line,
  input  logic [2:0]              word_sel,
  input  logic [31:0]             wdata,
  input  logic [3:0]              byte_enable,
  output logic [LB_LINE_BITS-1:0] merged
);
  genvar gi;
  generate
    for (gi = 0; gi < LB_LINE_BITS / 8; gi = gi + 1) begin : g_byte
      assign merged[8*gi +: 8] = (word_sel == 3'(gi / 4) && byte_enable[gi % 4])
                                 ? wdata[8*(gi % 4) +: 8] : line[8*gi +: 8];
    end
  endgenerate
endmodule

// File: rtl/line_buffer.sv
// Single 256-bit line buffer with 4-beat 64-bit fill/evict bursts.
// Define LINE_BUFFER_WRITEBACK_EN for write-back; otherwise write hits are written through.
module line_buffer
  import rv32i_types::*;
#(
  parameter int BEATS = LB_BEATS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [63:0] pmem_wdata,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp
);
`ifdef LINE_BUFFER_WRITEBACK_EN
  localparam bit WRITE_BACK = 1'b1;
`else
  localparam bit WRITE_BACK = 1'b0;
`endif
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  lb_state_t state_reg, state_next;
  logic [LB_BEATS-1:0][LB_BEAT_BITS-1:0] line_reg;
  logic [LB_WORDS-1:0][31:0]             words;
  logic [LB_LINE_BITS-1:0]               merged_line;
  logic [26:0] tag_reg;
  logic [31:0] addr_reg;
  logic [31:0] rdata_reg;
  logic [1:0]  beat_reg;
  logic        valid_reg, dirty_reg;

  logic        req, is_write, hit, last_beat;
  logic [26:0] req_tag;
  logic [2:0]  word_sel;
  logic        unused_addr;

  assign req         = mem_read | mem_write;
  assign is_write    = mem_write;
  assign req_tag     = mem_address[31:5];
  assign word_sel    = mem_address[4:2];
  assign unused_addr = ^mem_address[1:0];
  assign hit         = valid_reg && (tag_reg == req_tag);
  assign last_beat   = pmem_resp && (beat_reg == LAST_BEAT);
  assign words       = line_reg;

  assign mem_rdata    = rdata_reg;
  assign pmem_address = addr_reg;

  line_merge u_merge (
    .line        (line_reg),
    .word_sel    (word_sel),
    .wdata       (mem_wdata),
    .byte_enable (mem_byte_enable),
    .merged      (merged_line)
  );

  // Strobes decode straight from the state so reset drops them without waiting for a clock.
  always_comb begin
    state_next = state_reg;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_wdata = '0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (hit)            state_next = (is_write && !WRITE_BACK) ? WB : RESP;
          else if (dirty_reg) state_next = WB;
          else                state_next = FILL;
        end
      end
      RESP: begin
        mem_resp   = 1'b1;
        state_next = IDLE;
      end
      WB: begin
        pmem_write = 1'b1;
        pmem_wdata = line_reg[beat_reg];
        if (last_beat) state_next = WRITE_BACK ? FILL : RESP;
      end
      FILL: begin
        pmem_read = 1'b1;
        if (last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      valid_reg <= 1'b0;
      dirty_reg <= 1'b0;
      tag_reg   <= '0;
      addr_reg  <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req) begin
            beat_reg <= '0;
            if (hit) begin
              if (is_write) begin
                if (WRITE_BACK) dirty_reg <= 1'b1;
                else            addr_reg  <= {tag_reg, 5'b0};
              end else begin
                rdata_reg <= words[word_sel];
              end
            end else if (dirty_reg) begin
              addr_reg <= {tag_reg, 5'b0};
            end else begin
              addr_reg <= {req_tag, 5'b0};
            end
          end
        end
        WB: begin
          if (pmem_resp) begin
            beat_reg <= beat_reg + 2'd1;
            if (last_beat) begin
              dirty_reg <= 1'b0;
              beat_reg  <= '0;
              addr_reg  <= {req_tag, 5'b0};
            end
          end
        end
        FILL: begin
          if (pmem_resp) begin
            beat_reg <= beat_reg + 2'd1;
            if (last_beat) begin
              valid_reg <= 1'b1;
              tag_reg   <= addr_reg[31:5];
              beat_reg  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; its contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && req && hit && is_write)
      line_reg <= merged_line;
    else if (state_reg == FILL && pmem_resp)
      line_reg[beat_reg] <= pmem_rdata;
  end
endmodule

// File: tb/tb_line_buffer.sv
// Randomized self-checking bench for line_buffer against a single-line cache model.
module tb_line_buffer;
`ifdef LINE_BUFFER_WRITEBACK_EN
  localparam bit WB_MODE = 1'b1;
`else
  localparam bit WB_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] mem_address = '0, mem_wdata = '0;
  logic [3:0]  mem_byte_enable = '0;
  logic [31:0] mem_rdata;
  logic        mem_resp, pmem_read, pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  line_buffer #(.BEATS(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Physical memory seen by the DUT, and the model's own copy of what memory should hold.
  logic [63:0] phys_mem [int unsigned];
  logic [63:0] gold_mem [int unsigned];

  function automatic logic [63:0] pattern(input int unsigned k);
    logic [31:0] kk;
    kk = k;
    return {kk ^ 32'hA5A5_0000, ~kk};
  endfunction

  function automatic logic [63:0] phys_rd(input int unsigned k);
    if (phys_mem.exists(k)) return phys_mem[k];
    return pattern(k);
  endfunction

  function automatic logic [63:0] gold_rd(input int unsigned k);
    if (gold_mem.exists(k)) return gold_mem[k];
    return pattern(k);
  endfunction

  logic [32:0] act_bursts[$], exp_bursts[$];
  logic [63:0] act_wbeats[$], exp_wbeats[$];

  int rsp_beat = 0;
  int gap_mode = 0;
  logic [31:0] burst_addr = '0;

  // Burst memory responder: 0 = back-to-back, 1 = one idle cycle between beats, 2 = random.
  initial begin
    bit prev, give;
    int unsigned k;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (!rst_n) begin
        rsp_beat = 0;
        prev = 1'b0;
      end else if (pmem_read || pmem_write) begin
        give = 1'b1;
        if (gap_mode == 1) give = !prev;
        else if (gap_mode == 2) give = ($urandom_range(0, 2) != 0);
        prev = give;
        if (give) begin
          if (rsp_beat == 0) burst_addr = pmem_address;
          else check_value("pmem_addr_stable", 64'(pmem_address), 64'(burst_addr));
          k = (burst_addr >> 3) + rsp_beat;
          if (pmem_write) begin
            act_wbeats.push_back(pmem_wdata);
            phys_mem[k] = pmem_wdata;
          end else begin
            pmem_rdata = phys_rd(k);
          end
          pmem_resp = 1'b1;
          rsp_beat++;
          if (rsp_beat == 4) begin
            act_bursts.push_back({pmem_write, burst_addr});
            rsp_beat = 0;
          end
        end
      end else begin
        prev = 1'b0;
      end
    end
  end

  // Reference model: one line of eight words with valid/dirty/tag.
  bit          m_valid = 1'b0, m_dirty = 1'b0;
  logic [26:0] m_tag = '0;
  logic [31:0] m_words [8];

  task automatic model_flush(input logic [26:0] tag);
    int unsigned base;
    logic [63:0] beat;
    base = {tag, 5'b0} >> 3;
    exp_bursts.push_back({1'b1, tag, 5'b0});
    for (int i = 0; i < 4; i++) begin
      beat = {m_words[2*i+1], m_words[2*i]};
      exp_wbeats.push_back(beat);
      gold_mem[base + i] = beat;
    end
    m_dirty = 1'b0;
  endtask

  task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] rdata, output bit hit);
    logic [26:0] tag;
    int w;
    int unsigned base;
    logic [63:0] beat;
    tag = addr[31:5];
    w = int'(addr[4:2]);
    rdata = '0;
    hit = m_valid && (m_tag == tag);
    if (!hit) begin
      if (m_dirty) model_flush(m_tag);
      base = {tag, 5'b0} >> 3;
      exp_bursts.push_back({1'b0, tag, 5'b0});
      for (int i = 0; i < 4; i++) begin
        beat = gold_rd(base + i);
        m_words[2*i]   = beat[31:0];
        m_words[2*i+1] = beat[63:32];
      end
      m_valid = 1'b1;
      m_tag = tag;
    end
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_words[w][8*b +: 8] = wdata[8*b +: 8];
      if (WB_MODE) m_dirty = 1'b1;
      else model_flush(m_tag);
    end else begin
      rdata = m_words[w];
    end
  endtask

  task automatic compare_bursts();
    check_value("n_bursts", 64'(act_bursts.size()), 64'(exp_bursts.size()));
    for (int i = 0; i < exp_bursts.size() && i < act_bursts.size(); i++)
      check_value("burst", 64'(act_bursts[i]), 64'(exp_bursts[i]));
    check_value("n_wbeats", 64'(act_wbeats.size()), 64'(exp_wbeats.size()));
    for (int i = 0; i < exp_wbeats.size() && i < act_wbeats.size(); i++)
      check_value("wbeat", act_wbeats[i], exp_wbeats[i]);
    act_bursts.delete();
    exp_bursts.delete();
    act_wbeats.delete();
    exp_wbeats.delete();
  endtask

  task automatic cpu_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] exp_rd;
    bit hit, got;
    int lat;
    model_access(wr, addr, wdata, be, exp_rd, hit);
    @(negedge clk);
    mem_read = rd;
    mem_write = wr;
    mem_address = addr;
    mem_wdata = wdata;
    mem_byte_enable = be;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      got = mem_resp;
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    check_value("resp_seen", 64'(got), 64'(1));
    if (!wr) check_value("rdata", 64'(mem_rdata), 64'(exp_rd));
    if (hit && (!wr || WB_MODE)) check_value("hit_latency", 64'(lat), 64'(1));
    @(posedge clk);
    #1;
    check_value("resp_pulse", 64'(mem_resp), 64'(0));
    compare_bursts();
    check_value("beat_idle", 64'(rsp_beat), 64'(0));
    n_txn++;
    $display("txn %0d: rd=%0b wr=%0b addr=%h wdata=%h be=%b hit=%0b lat=%0d rdata=%h",
             n_txn, rd, wr, addr, wdata, be, hit, lat, mem_rdata);
  endtask

  task automatic reset_mid_fill();
    int n;
    @(negedge clk);
    gap_mode = 1;
    mem_read = 1'b1;
    mem_address = 32'h0000_3000;
    n = 0;
    while (rsp_beat != 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_value("fill_reached", 64'(rsp_beat), 64'(2));
    check_value("pmem_read_pre", 64'(pmem_read), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_value("rst_pmem_read", 64'(pmem_read), 64'(0));
    check_value("rst_pmem_write", 64'(pmem_write), 64'(0));
    check_value("rst_mem_resp", 64'(mem_resp), 64'(0));
    check_value("rst_pmem_addr", 64'(pmem_address), 64'(0));
    check_value("rst_mem_rdata", 64'(mem_rdata), 64'(0));
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    act_bursts.delete();
    act_wbeats.delete();
    exp_bursts.delete();
    exp_wbeats.delete();
    m_valid = 1'b0;
    m_dirty = 1'b0;
    n_txn++;
    $display("txn %0d: reset asserted during fill of 0x3000 after %0d cycles", n_txn, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [26:0] tags [4];
    logic [31:0] addr;
    int op;
    tags[0] = 27'h2;
    tags[1] = 27'h80;
    tags[2] = 27'h81;
    tags[3] = 27'h3F0;

    #12;
    check_value("reset_mem_resp", 64'(mem_resp), 64'(0));
    check_value("reset_mem_rdata", 64'(mem_rdata), 64'(0));
    check_value("reset_pmem_read", 64'(pmem_read), 64'(0));
    check_value("reset_pmem_write", 64'(pmem_write), 64'(0));
    check_value("reset_pmem_addr", 64'(pmem_address), 64'(0));
    check_value("reset_pmem_wdata", pmem_wdata, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      phys_mem[8 + i] = {16{4'(i + 1)}};
      gold_mem[8 + i] = {16{4'(i + 1)}};
    end

    gap_mode = 1;
    cpu_access(1'b1, 1'b0, 32'h0000_0040, '0, '0);
    gap_mode = 0;
    cpu_access(1'b1, 1'b0, 32'h0000_0044, '0, '0);
    cpu_access(1'b0, 1'b1, 32'h0000_0048, 32'hAABB_CCDD, 4'b0101);
    cpu_access(1'b1, 1'b0, 32'h0000_0048, '0, '0);
    cpu_access(1'b1, 1'b0, 32'h0000_1000, '0, '0);

    reset_mid_fill();
    gap_mode = 0;
    cpu_access(1'b1, 1'b0, 32'h0000_0040, '0, '0);
    cpu_access(1'b1, 1'b1, 32'h0000_004C, 32'h1234_5678, 4'hF);
    cpu_access(1'b1, 1'b0, 32'h0000_004C, '0, '0);
    cpu_access(1'b0, 1'b1, 32'h0000_0050, 32'hDEAD_BEEF, 4'b0000);
    cpu_access(1'b1, 1'b0, 32'h0000_0050, '0, '0);

    for (int t = 0; t < 80; t++) begin
      gap_mode = int'($urandom_range(0, 2));
      addr = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op = int'($urandom_range(0, 3));
      cpu_access(op != 2, op >= 2, addr, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
